// File: rtl/act_func.sv
// Registered activation function (ReLU / STEP / hard-sigmoid, plus leaky ReLU
// when ACT_FUNC_LEAKY_EN is defined) with a fixed one-cycle latency.
`ifndef Enable
`define Enable 1'b1
`endif
`ifndef Disable
`define Disable 1'b0
`endif

package act_func_pkg;
  typedef enum logic [0:0] {INT, FXP} dtype_t;
  typedef enum logic [1:0] {ReLU, STEP, HSIG, LReLU} actf_t;

  typedef struct packed {
    dtype_t dtype;
    logic   sign;
    int     prec;
    int     frac;
  } dconf_t;
endpackage

module act_func
  import act_func_pkg::*;
#(
  parameter dconf_t CONF = dconf_t'{dtype: FXP, sign: `Enable, prec: 8, frac: 3},
  parameter actf_t  ACT  = ReLU
) (
  input  logic                 clk,
  input  logic                 reset_,
  input  logic                 in_valid,
  input  logic [CONF.prec-1:0] in,
  output logic                 out_valid,
  output logic [CONF.prec-1:0] out
);

  localparam int  PREC     = CONF.prec;
  localparam int  FRAC     = (CONF.dtype == INT) ? 0 : CONF.frac;
  localparam bit  SGN      = CONF.sign;
  localparam int  FRAC_MAX = SGN ? PREC - 2 : PREC - 1;
  localparam int  W        = PREC + 2;

  localparam logic        [PREC-1:0] ONE   = PREC'(1) << FRAC;
  localparam logic signed [W-1:0]    ONE_W = W'(ONE);
  localparam logic signed [W-1:0]    HALF  = W'(ONE >> 1);

  // Configurations that cannot be built are rejected at elaboration
  if (PREC < 2) begin : g_err_prec
    $error("act_func: PREC must be at least 2");
  end
  if (FRAC < 0 || FRAC > FRAC_MAX) begin : g_err_frac
    $error("act_func: FRAC out of range, constant ONE not representable");
  end
`ifndef ACT_FUNC_LEAKY_EN
  if (ACT == LReLU) begin : g_err_leaky
    $error("act_func: LReLU requested but ACT_FUNC_LEAKY_EN is not defined");
  end
`endif

  logic                  neg;
  logic signed [W-1:0]   hext;
  logic signed [W-1:0]   hshift;
  logic signed [W-1:0]   hsum;
  logic [PREC-1:0]       f;

  assign neg    = SGN && in[PREC-1];
  // Hard sigmoid is evaluated two bits wider so the offset add cannot wrap
  assign hext   = {{2{neg}}, in};
  assign hshift = hext >>> 2;
  assign hsum   = HALF + hshift;

`ifdef ACT_FUNC_LEAKY_EN
  logic signed [PREC-1:0] lin;
  logic signed [PREC-1:0] lsh;
  assign lin = in;
  assign lsh = lin >>> 3;
`endif

  always_comb begin
    f = '0;
    case (ACT)
      ReLU: f = neg ? '0 : in;
      STEP: f = (!neg && (in != '0)) ? ONE : '0;
      HSIG: begin
        if (hsum < 0)
          f = '0;
        else if (hsum > ONE_W)
          f = ONE;
        else
          f = hsum[PREC-1:0];
      end
`ifdef ACT_FUNC_LEAKY_EN
      LReLU: f = neg ? lsh : in;
`endif
      default: f = '0;
    endcase
  end

  // Result register holds its value through gaps in the input stream
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      out_valid <= 1'b0;
      out       <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid)
        out <= f;
    end
  end

endmodule

// File: tb/tb_act_func.sv
// Self-checking bench for act_func: several configurations side by side,
// compared against a real-valued floor-rounding model every cycle.
`ifndef Enable
`define Enable 1'b1
`endif

module tb_act_func;
  import act_func_pkg::*;

`ifdef ACT_FUNC_LEAKY_EN
  localparam int NDUT = 10;
`else
  localparam int NDUT = 8;
`endif

  localparam actf_t  ACTS [10] = '{ReLU, STEP, HSIG, ReLU, STEP, HSIG, STEP, HSIG, LReLU, LReLU};
  localparam dtype_t DTS  [10] = '{FXP, FXP, FXP, FXP, FXP, FXP, INT, INT, FXP, FXP};
  localparam bit     SGS  [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam int     FRS  [10] = '{3, 3, 3, 3, 3, 3, 0, 0, 3, 3};

  logic       clk = 1'b0;
  logic       reset_ = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout [NDUT];
  logic       dval [NDUT];

  logic [7:0] exp_out [NDUT];
  logic       exp_v = 1'b0;
  bit         check_en = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    act_func #(
      .CONF(dconf_t'{dtype: DTS[g], sign: SGS[g], prec: 8, frac: FRS[g]}),
      .ACT (ACTS[g])
    ) u_dut (
      .clk      (clk),
      .reset_   (reset_),
      .in_valid (in_valid),
      .in       (din),
      .out_valid(dval[g]),
      .out      (dout[g])
    );
  end

  // Reference: interpret the operand as a real number, apply the function,
  // then floor back onto the fixed-point grid
  function automatic logic [7:0] model(actf_t act, bit sgn, int frac, logic [7:0] x);
    real scale, v, r;
    int  xi, q;
    scale = 2.0 ** frac;
    xi = sgn ? int'($signed(x)) : int'(x);
    v = xi / scale;
    case (act)
      ReLU: r = (v < 0.0) ? 0.0 : v;
      STEP: r = (v > 0.0) ? 1.0 : 0.0;
      HSIG: begin
        r = ((frac == 0) ? 0.0 : 0.5) + v / 4.0;
        if (r < 0.0) r = 0.0;
        if (r > 1.0) r = 1.0;
      end
      default: r = (v < 0.0) ? v / 8.0 : v;
    endcase
    q = int'($floor(r * scale));
    return q[7:0];
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got=%02h want=%02h", name, got, want);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] x);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    din = x;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Expected pipeline: one-cycle latency, value held while idle
  always @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      exp_v <= 1'b0;
      for (int i = 0; i < NDUT; i++) exp_out[i] <= 8'h00;
    end else begin
      exp_v <= in_valid;
      if (in_valid)
        for (int i = 0; i < NDUT; i++)
          exp_out[i] <= model(ACTS[i], SGS[i], FRS[i], din);
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < NDUT; i++) begin
        checkOutput($sformatf("stream valid dut%0d", i), {7'b0, dval[i]}, {7'b0, exp_v});
        checkOutput($sformatf("stream out dut%0d", i), dout[i], exp_out[i]);
      end
    end
  end

  typedef struct {
    int         idx;
    logic [7:0] x;
    logic [7:0] e;
  } vec_t;

  vec_t vecs [$];

  task automatic checkAllZero(input string tag);
    for (int i = 0; i < NDUT; i++) begin
      checkOutput($sformatf("%s valid dut%0d", tag, i), {7'b0, dval[i]}, 8'h00);
      checkOutput($sformatf("%s out dut%0d", tag, i), dout[i], 8'h00);
    end
  endtask

  initial begin
    vecs.push_back('{0, 8'h1C, 8'h1C});
    vecs.push_back('{0, 8'hE4, 8'h00});
    vecs.push_back('{0, 8'h00, 8'h00});
    vecs.push_back('{1, 8'h1C, 8'h08});
    vecs.push_back('{1, 8'hE4, 8'h00});
    vecs.push_back('{1, 8'h00, 8'h00});
    vecs.push_back('{1, 8'h01, 8'h08});
    vecs.push_back('{2, 8'h00, 8'h04});
    vecs.push_back('{2, 8'h10, 8'h08});
    vecs.push_back('{2, 8'h7F, 8'h08});
    vecs.push_back('{2, 8'hE0, 8'h00});
    vecs.push_back('{2, 8'hF8, 8'h02});
    vecs.push_back('{3, 8'hE4, 8'hE4});
    vecs.push_back('{4, 8'h80, 8'h08});
    vecs.push_back('{5, 8'h80, 8'h08});
    vecs.push_back('{5, 8'h04, 8'h05});
    vecs.push_back('{6, 8'h03, 8'h01});
    vecs.push_back('{6, 8'hFF, 8'h00});
    vecs.push_back('{7, 8'h03, 8'h00});
    vecs.push_back('{7, 8'h08, 8'h01});
`ifdef ACT_FUNC_LEAKY_EN
    vecs.push_back('{8, 8'hE4, 8'hFC});
    vecs.push_back('{8, 8'h80, 8'hF0});
    vecs.push_back('{8, 8'h1C, 8'h1C});
    vecs.push_back('{9, 8'h80, 8'h80});
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    reset_ = 1'b1;
    check_en = 1'b1;

    // Directed vectors pin both the DUT and the model to literal values
    foreach (vecs[k]) begin
      applyStimulus(vecs[k].x);
      checkOutput($sformatf("vec dut%0d in=%02h", vecs[k].idx, vecs[k].x),
                  dout[vecs[k].idx], vecs[k].e);
      checkOutput($sformatf("vec valid dut%0d", vecs[k].idx), {7'b0, dval[vecs[k].idx]}, 8'h01);
      checkOutput($sformatf("model dut%0d in=%02h", vecs[k].idx, vecs[k].x),
                  model(ACTS[vecs[k].idx], SGS[vecs[k].idx], FRS[vecs[k].idx], vecs[k].x),
                  vecs[k].e);
    end

    // Output holds during an idle cycle
    applyStimulus(8'h1C);
    @(posedge clk);
    #1;
    checkOutput("hold valid", {7'b0, dval[0]}, 8'h00);
    checkOutput("hold out", dout[0], 8'h1C);

    // in_valid toggling every cycle
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      in_valid = k[0];
      din = 8'($urandom);
    end

    // Random stream with a reset dropped in mid-flight
    for (int k = 0; k < 1200; k++) begin
      if (k == 600) begin
        @(posedge clk);
        in_valid = 1'b1;
        #3;
        reset_ = 1'b0;
        #1;
        checkAllZero("midreset");
        @(posedge clk);
        #1;
        reset_ = 1'b1;
      end
      @(posedge clk);
      #1;
      in_valid = ($urandom_range(0, 9) != 0);
      din = 8'($urandom);
    end

    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
